// File: rtl/pspin_match_rule_ctrl.sv
// pspin_match_rule_ctrl
//   Register-mapped rule controller for the PsPIN packet match engine.
//   Software writes match rules into shadow registers. A commit copies every
//   shadow rule to the live match_* bus in one cycle. The copy waits until no
//   frame is in flight through the engine, so rules only change between
//   packets. If the engine never goes quiet, a timeout forces the commit.
//
// Optional build macro: PSPIN_MATCH_RULE_CTRL_STATS_EN
//   When defined, adds the MATCHED (0x0C) and UNMATCHED (0x20*ENTRIES+0x10)
//   frame counters. Without it, both addresses read 0 and ignore writes.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reg_wr_addr/data/en, _ack     register write (ack one cycle after en)
//   reg_rd_addr/en, _data, _ack   register read (data valid in the ack cycle)
//   snoop_in_*                    matcher ingress AXI-Stream handshake
//   snoop_nic_*                   unmatched egress AXI-Stream handshake
//   snoop_pspin_*                 matched egress AXI-Stream handshake
//   match_mode/idx/mask/start/end live rules, entry i at [i*W +: W]
//   match_valid                   live rules enabled
//
// Register map (byte addresses, word aligned)
//   0x00 CTRL      bit0 mode, bit1 enable (shadow)
//   0x04 COMMIT    wr bit0 request commit, wr bit1 clear forced flag
//                  rd bit0 pending, bit1 forced
//   0x08 INFLIGHT  in-flight frame count (RO)
//   0x10+0x10*i    entry i: +0 idx, +4 mask, +8 start, +C end (shadow)
module pspin_match_rule_ctrl #(
   parameter int UMATCH_WIDTH   = 32,
   parameter int UMATCH_ENTRIES = 4,
   parameter int UMATCH_MODES   = 2,
   parameter int REG_ADDR_WIDTH = 10,
   parameter int REG_DATA_WIDTH = 32,
   parameter int INFLIGHT_WIDTH = 8,
   parameter int COMMIT_TIMEOUT = 65535,
   localparam int MODE_W = (UMATCH_MODES > 1) ? $clog2(UMATCH_MODES) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [REG_ADDR_WIDTH-1:0]              reg_wr_addr,
   input  logic [REG_DATA_WIDTH-1:0]              reg_wr_data,
   input  logic                                   reg_wr_en,
   output logic                                   reg_wr_ack,
   input  logic [REG_ADDR_WIDTH-1:0]              reg_rd_addr,
   input  logic                                   reg_rd_en,
   output logic [REG_DATA_WIDTH-1:0]              reg_rd_data,
   output logic                                   reg_rd_ack,
   input  logic                                   snoop_in_valid,
   input  logic                                   snoop_in_ready,
   input  logic                                   snoop_in_last,
   input  logic                                   snoop_nic_valid,
   input  logic                                   snoop_nic_ready,
   input  logic                                   snoop_nic_last,
   input  logic                                   snoop_pspin_valid,
   input  logic                                   snoop_pspin_ready,
   input  logic                                   snoop_pspin_last,
   output logic [MODE_W-1:0]                      match_mode,
   output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_idx,
   output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_mask,
   output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_start,
   output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_end,
   output logic                                   match_valid
);

   localparam int AW  = REG_ADDR_WIDTH;
   localparam int DW  = REG_DATA_WIDTH;
   localparam int W   = UMATCH_WIDTH;
   localparam int E   = UMATCH_ENTRIES;
   localparam int IW  = INFLIGHT_WIDTH;
   localparam int WAW = AW - 2;

   localparam logic [WAW-1:0] WA_CTRL     = WAW'(0);
   localparam logic [WAW-1:0] WA_COMMIT   = WAW'(1);
   localparam logic [WAW-1:0] WA_INFLIGHT = WAW'(2);

   localparam int TIMER_W = (COMMIT_TIMEOUT > 1) ? $clog2(COMMIT_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST =
      TIMER_W'((COMMIT_TIMEOUT > 0) ? COMMIT_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Address decode. Misaligned byte addresses are treated as unmapped.
   // ---------------------------------------------------------------------
   logic           wr_sel;
   logic           rd_sel;
   logic [WAW-1:0] wr_word;
   logic [WAW-1:0] rd_word;
   logic           wr_commit;

   assign wr_sel    = reg_wr_en && (reg_wr_addr[1:0] == 2'b00);
   assign rd_sel    = (reg_rd_addr[1:0] == 2'b00);
   assign wr_word   = reg_wr_addr[AW-1:2];
   assign rd_word   = reg_rd_addr[AW-1:2];
   assign wr_commit = wr_sel && (wr_word == WA_COMMIT);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t              state_reg, state_next;
   logic [TIMER_W-1:0]  timer_reg, timer_next;
   logic                pending_reg;
   logic                forced_reg;
   logic                force_hit;
   logic                load_live;
   logic                shadow_en_reg;
   logic [MODE_W-1:0]   shadow_mode_reg;
   logic [IW-1:0]       inflight_reg, inflight_next;
   logic                in_pkt_reg;
   logic                quiet;
   logic [W-1:0]        shadow_idx_reg   [E];
   logic [W-1:0]        shadow_mask_reg  [E];
   logic [W-1:0]        shadow_start_reg [E];
   logic [W-1:0]        shadow_end_reg   [E];
   logic [DW-1:0]       rd_value;
   logic                wr_ack_reg, rd_ack_reg;
   logic [DW-1:0]       rd_data_reg;

   // ---------------------------------------------------------------------
   // In-flight frame tracking
   // ---------------------------------------------------------------------
   logic in_beat, in_eof, nic_eof, pspin_eof;
   logic [IW+1:0] cnt_up, cnt_down, cnt_diff;

   assign in_beat   = snoop_in_valid && snoop_in_ready;
   assign in_eof    = in_beat && snoop_in_last;
   assign nic_eof   = snoop_nic_valid && snoop_nic_ready && snoop_nic_last;
   assign pspin_eof = snoop_pspin_valid && snoop_pspin_ready && snoop_pspin_last;

   // Evaluate the net change in a wider field so both saturation limits
   // can be detected without wrapping.
   assign cnt_up   = (IW+2)'(inflight_reg) + (IW+2)'(in_eof);
   assign cnt_down = (IW+2)'(nic_eof) + (IW+2)'(pspin_eof);
   assign cnt_diff = cnt_up - cnt_down;

   always_comb begin
      inflight_next = cnt_diff[IW-1:0];
      if (cnt_up < cnt_down) begin
         inflight_next = '0;
      end else if (cnt_diff > (IW+2)'({IW{1'b1}})) begin
         inflight_next = {IW{1'b1}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_reg <= '0;
         in_pkt_reg   <= 1'b0;
      end else begin
         inflight_reg <= inflight_next;
         if (in_beat) begin
            in_pkt_reg <= !snoop_in_last;
         end
      end
   end

   // A beat accepted this cycle means a frame is starting or continuing.
   assign quiet = (inflight_reg == '0) && !in_pkt_reg && !in_beat;

   // ---------------------------------------------------------------------
   // Commit FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         timer_reg <= '0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      force_hit  = 1'b0;
      load_live  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (wr_commit && reg_wr_data[0]) begin
               state_next = ST_WAIT;
               timer_next = '0;
            end
         end
         ST_WAIT: begin
            timer_next = timer_reg + 1'b1;
            if (quiet) begin
               state_next = ST_COMMIT;
            end else if ((COMMIT_TIMEOUT != 0) && (timer_reg == TIMER_LAST)) begin
               state_next = ST_COMMIT;
               force_hit  = 1'b1;
            end
         end
         ST_COMMIT: begin
            load_live  = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Pending / forced flags, CTRL shadow, register acks.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg     <= 1'b0;
         forced_reg      <= 1'b0;
         shadow_en_reg   <= 1'b0;
         shadow_mode_reg <= '0;
         wr_ack_reg      <= 1'b0;
         rd_ack_reg      <= 1'b0;
         rd_data_reg     <= '0;
      end else begin
         if ((state_reg == ST_IDLE) && (state_next == ST_WAIT)) begin
            pending_reg <= 1'b1;
         end else if (load_live) begin
            pending_reg <= 1'b0;
         end
         // A timeout landing in the same cycle as a clear keeps the flag set.
         if (force_hit) begin
            forced_reg <= 1'b1;
         end else if (wr_commit && reg_wr_data[1]) begin
            forced_reg <= 1'b0;
         end
         if (wr_sel && (wr_word == WA_CTRL)) begin
            shadow_mode_reg <= reg_wr_data[MODE_W-1:0];
            shadow_en_reg   <= reg_wr_data[1];
         end
         wr_ack_reg  <= reg_wr_en;
         rd_ack_reg  <= reg_rd_en;
         rd_data_reg <= reg_rd_en ? rd_value : '0;
      end
   end

   // Live mode / enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         match_mode  <= '0;
         match_valid <= 1'b0;
      end else if (load_live) begin
         match_mode  <= shadow_mode_reg;
         match_valid <= shadow_en_reg;
      end
   end

   // ---------------------------------------------------------------------
   // Rule entries: shadow storage plus live copy
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < E; gi++) begin : g_entry
         localparam logic [AW-5:0] BLK = (AW-4)'(gi + 1);
         logic         wr_hit;
         logic [W-1:0] live_idx_reg, live_mask_reg, live_start_reg, live_end_reg;

         assign wr_hit = wr_sel && (reg_wr_addr[AW-1:4] == BLK);

         always_ff @(posedge clk) begin
            if (rst) begin
               shadow_idx_reg[gi]   <= '0;
               shadow_mask_reg[gi]  <= '0;
               shadow_start_reg[gi] <= '0;
               shadow_end_reg[gi]   <= '0;
               live_idx_reg         <= '0;
               live_mask_reg        <= '0;
               live_start_reg       <= '0;
               live_end_reg         <= '0;
            end else begin
               if (wr_hit) begin
                  case (reg_wr_addr[3:2])
                     2'd0:    shadow_idx_reg[gi]   <= reg_wr_data;
                     2'd1:    shadow_mask_reg[gi]  <= reg_wr_data;
                     2'd2:    shadow_start_reg[gi] <= reg_wr_data;
                     default: shadow_end_reg[gi]   <= reg_wr_data;
                  endcase
               end
               if (load_live) begin
                  live_idx_reg   <= shadow_idx_reg[gi];
                  live_mask_reg  <= shadow_mask_reg[gi];
                  live_start_reg <= shadow_start_reg[gi];
                  live_end_reg   <= shadow_end_reg[gi];
               end
            end
         end

         assign match_idx[gi*W +: W]   = live_idx_reg;
         assign match_mask[gi*W +: W]  = live_mask_reg;
         assign match_start[gi*W +: W] = live_start_reg;
         assign match_end[gi*W +: W]   = live_end_reg;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Frame statistics
   // ---------------------------------------------------------------------
`ifdef PSPIN_MATCH_RULE_CTRL_STATS_EN
   localparam logic [WAW-1:0] WA_MATCHED   = WAW'(3);
   localparam logic [WAW-1:0] WA_UNMATCHED = WAW'((32*E + 16) / 4);

   logic [31:0] matched_reg, unmatched_reg;
   logic        stats_clr;

   assign stats_clr = wr_sel && ((wr_word == WA_MATCHED) || (wr_word == WA_UNMATCHED));

   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         matched_reg   <= '0;
         unmatched_reg <= '0;
      end else begin
         matched_reg   <= matched_reg + 32'(pspin_eof);
         unmatched_reg <= unmatched_reg + 32'(nic_eof);
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Read mux (shadow values, never live ones)
   // ---------------------------------------------------------------------
   always_comb begin
      rd_value = '0;
      if (rd_sel) begin
         if (rd_word == WA_CTRL) begin
            rd_value[MODE_W-1:0] = shadow_mode_reg;
            rd_value[1]          = shadow_en_reg;
         end else if (rd_word == WA_COMMIT) begin
            rd_value[0] = pending_reg;
            rd_value[1] = forced_reg;
         end else if (rd_word == WA_INFLIGHT) begin
            rd_value[IW-1:0] = inflight_reg;
         end
`ifdef PSPIN_MATCH_RULE_CTRL_STATS_EN
         else if (rd_word == WA_MATCHED) begin
            rd_value = matched_reg;
         end else if (rd_word == WA_UNMATCHED) begin
            rd_value = unmatched_reg;
         end
`endif
         for (int i = 0; i < E; i++) begin
            if (reg_rd_addr[AW-1:4] == (AW-4)'(i + 1)) begin
               case (reg_rd_addr[3:2])
                  2'd0:    rd_value = shadow_idx_reg[i];
                  2'd1:    rd_value = shadow_mask_reg[i];
                  2'd2:    rd_value = shadow_start_reg[i];
                  default: rd_value = shadow_end_reg[i];
               endcase
            end
         end
      end
   end

   assign reg_wr_ack  = wr_ack_reg;
   assign reg_rd_ack  = rd_ack_reg;
   assign reg_rd_data = rd_data_reg;

endmodule

// File: tb/tb_pspin_match_rule_ctrl.sv
// Testbench for pspin_match_rule_ctrl: table-driven register accesses plus
// hand-written sequences for commit latency, in-flight blocking, timeout,
// counter saturation, reset mid-commit and the optional statistics block.
module tb_pspin_match_rule_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic [9:0]   reg_wr_addr, reg_rd_addr;
   logic [31:0]  reg_wr_data;
   logic         reg_wr_en, reg_rd_en;
   logic         reg_wr_ack, reg_rd_ack;
   logic [31:0]  reg_rd_data;
   logic         in_valid, in_ready, in_last;
   logic         nic_valid, nic_ready, nic_last;
   logic         ps_valid, ps_ready, ps_last;
   logic         match_mode;
   logic [127:0] match_idx, match_mask, match_start, match_end;
   logic         match_valid;

   int n_tests = 0;
   int n_fail  = 0;

   pspin_match_rule_ctrl #(
      .COMMIT_TIMEOUT(16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .reg_wr_addr       (reg_wr_addr),
      .reg_wr_data       (reg_wr_data),
      .reg_wr_en         (reg_wr_en),
      .reg_wr_ack        (reg_wr_ack),
      .reg_rd_addr       (reg_rd_addr),
      .reg_rd_en         (reg_rd_en),
      .reg_rd_data       (reg_rd_data),
      .reg_rd_ack        (reg_rd_ack),
      .snoop_in_valid    (in_valid),
      .snoop_in_ready    (in_ready),
      .snoop_in_last     (in_last),
      .snoop_nic_valid   (nic_valid),
      .snoop_nic_ready   (nic_ready),
      .snoop_nic_last    (nic_last),
      .snoop_pspin_valid (ps_valid),
      .snoop_pspin_ready (ps_ready),
      .snoop_pspin_last  (ps_last),
      .match_mode        (match_mode),
      .match_idx         (match_idx),
      .match_mask        (match_mask),
      .match_start       (match_start),
      .match_end         (match_end),
      .match_valid       (match_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [9:0] addr, input logic [31:0] data);
      reg_wr_addr = addr;
      reg_wr_data = data;
      reg_wr_en   = 1'b1;
      tick();
      reg_wr_en   = 1'b0;
      $display("[TB] WR addr=%03h data=%08h ack=%0b", addr, data, reg_wr_ack);
      check("wr_ack", 128'(reg_wr_ack), 128'(1));
   endtask

   task automatic reg_read(input logic [9:0] addr, input logic [31:0] exp);
      reg_rd_addr = addr;
      reg_rd_en   = 1'b1;
      tick();
      reg_rd_en   = 1'b0;
      $display("[TB] RD addr=%03h data=%08h exp=%08h ack=%0b", addr, reg_rd_data, exp, reg_rd_ack);
      check("rd_ack", 128'(reg_rd_ack), 128'(1));
      check($sformatf("rd_data@%03h", addr), 128'(reg_rd_data), 128'(exp));
   endtask

   // One cycle of snoop traffic; every asserted port handshakes (ready=1).
   task automatic pulse(input bit ib, input bit il, input bit nic, input bit ps);
      in_valid  = ib;  in_ready  = 1'b1; in_last  = il;
      nic_valid = nic; nic_ready = 1'b1; nic_last = 1'b1;
      ps_valid  = ps;  ps_ready  = 1'b1; ps_last  = 1'b1;
      tick();
      in_valid  = 1'b0; nic_valid = 1'b0; ps_valid = 1'b0;
      in_last   = 1'b0;
      $display("[TB] SNOOP in=%0b last=%0b nic=%0b pspin=%0b", ib, il, nic, ps);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 10'h010, 32'h0000_0003, 32'h0};
      vecs[1]  = '{1'b1, 10'h014, 32'h0000_FFFF, 32'h0};
      vecs[2]  = '{1'b1, 10'h018, 32'h0000_0800, 32'h0};
      vecs[3]  = '{1'b1, 10'h01C, 32'h0000_0800, 32'h0};
      vecs[4]  = '{1'b1, 10'h000, 32'h0000_0002, 32'h0};
      vecs[5]  = '{1'b0, 10'h014, 32'h0,         32'h0000_FFFF};
      vecs[6]  = '{1'b0, 10'h010, 32'h0,         32'h0000_0003};
      vecs[7]  = '{1'b0, 10'h000, 32'h0,         32'h0000_0002};
      vecs[8]  = '{1'b0, 10'h008, 32'h0,         32'h0};
      vecs[9]  = '{1'b0, 10'h004, 32'h0,         32'h0};
      vecs[10] = '{1'b0, 10'h3FC, 32'h0,         32'h0};
      vecs[11] = '{1'b1, 10'h3FC, 32'hDEAD_BEEF, 32'h0};
      vecs[12] = '{1'b0, 10'h3FC, 32'h0,         32'h0};
      vecs[13] = '{1'b0, 10'h014, 32'h0,         32'h0000_FFFF};
      vecs[14] = '{1'b1, 10'h024, 32'h0000_1234, 32'h0};
      vecs[15] = '{1'b0, 10'h024, 32'h0,         32'h0000_1234};
      vecs[16] = '{1'b1, 10'h04C, 32'h0000_ABCD, 32'h0};
      vecs[17] = '{1'b0, 10'h04C, 32'h0,         32'h0000_ABCD};
      vecs[18] = '{1'b1, 10'h050, 32'h0000_0005, 32'h0};
      vecs[19] = '{1'b0, 10'h050, 32'h0,         32'h0};

      rst = 1'b1;
      reg_wr_addr = '0; reg_wr_data = '0; reg_wr_en = 1'b0;
      reg_rd_addr = '0; reg_rd_en = 1'b0;
      in_valid = 1'b0; in_ready = 1'b0; in_last = 1'b0;
      nic_valid = 1'b0; nic_ready = 1'b0; nic_last = 1'b0;
      ps_valid = 1'b0; ps_ready = 1'b0; ps_last = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_idx",   match_idx,   128'h0);
      check("rst_mask",  match_mask,  128'h0);
      check("rst_start", match_start, 128'h0);
      check("rst_end",   match_end,   128'h0);
      check("rst_mode",  128'(match_mode),  128'h0);
      check("rst_valid", 128'(match_valid), 128'h0);
      check("rst_wrack", 128'(reg_wr_ack),  128'h0);
      check("rst_rdack", 128'(reg_rd_ack),  128'h0);
      check("rst_rdata", 128'(reg_rd_data), 128'h0);
      rst = 1'b0;
      tick();

      // Shadow programming and readback, unmapped accesses
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].data);
         else            reg_read(vecs[i].addr, vecs[i].exp);
      end
      tick();
      check("rd_data_idle", 128'(reg_rd_data), 128'h0);
      check("rd_ack_idle",  128'(reg_rd_ack),  128'h0);
      check("live_before_commit", match_idx, 128'h0);

      // Quiet commit: live outputs change exactly 2 cycles after the write
      reg_write(10'h004, 32'h1);
      check("q_lat0_valid", 128'(match_valid), 128'h0);
      tick();
      check("q_lat1_valid", 128'(match_valid), 128'h0);
      check("q_lat1_idx",   match_idx, 128'h0);
      tick();
      check("q_idx",   match_idx,   128'h3);
      check("q_mask",  match_mask,  {32'h0, 32'h0, 32'h1234, 32'hFFFF});
      check("q_start", match_start, 128'h800);
      check("q_end",   match_end,   {32'hABCD, 32'h0, 32'h0, 32'h800});
      check("q_mode",  128'(match_mode),  128'h0);
      check("q_valid", 128'(match_valid), 128'h1);
      reg_read(10'h004, 32'h0);

      // Commit blocked by a frame in flight
      reg_write(10'h010, 32'h7);
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      pulse(1, 1, 0, 0);
      reg_write(10'h004, 32'h1);
      tick();
      tick();
      check("blk_idx_hold", match_idx[31:0], 128'h3);
      reg_read(10'h008, 32'h1);
      reg_read(10'h004, 32'h1);
      pulse(0, 0, 0, 1);
      check("blk_e0", match_idx[31:0], 128'h3);
      tick();
      check("blk_e1", match_idx[31:0], 128'h3);
      tick();
      check("blk_e2", match_idx[31:0], 128'h7);
      reg_read(10'h004, 32'h0);

      // Forced commit after 16 WAIT cycles with ingress stalled mid-frame
      pulse(1, 0, 0, 0);
      reg_write(10'h010, 32'h9);
      reg_write(10'h004, 32'h1);
      repeat (15) tick();
      check("to_w15", match_idx[31:0], 128'h7);
      tick();
      check("to_w16", match_idx[31:0], 128'h7);
      tick();
      check("to_w17", match_idx[31:0], 128'h9);
      reg_read(10'h004, 32'h2);
      reg_write(10'h004, 32'h2);
      reg_read(10'h004, 32'h0);
      pulse(1, 1, 0, 0);
      reg_read(10'h008, 32'h1);

      // Simultaneous ingress/egress, underflow, overflow
      pulse(1, 1, 0, 1);
      reg_read(10'h008, 32'h1);
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      reg_read(10'h008, 32'h0);
      pulse(0, 0, 1, 1);
      reg_read(10'h008, 32'h0);
      for (int i = 0; i < 260; i++) pulse(1, 1, 0, 0);
      reg_read(10'h008, 32'hFF);
      pulse(0, 0, 1, 0);
      reg_read(10'h008, 32'hFE);

      // Reset in the middle of WAIT abandons the commit
      reg_write(10'h010, 32'h55);
      reg_write(10'h004, 32'h1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rw_idx",   match_idx,   128'h0);
      check("rw_mask",  match_mask,  128'h0);
      check("rw_valid", 128'(match_valid), 128'h0);
      reg_read(10'h004, 32'h0);
      reg_read(10'h008, 32'h0);
      reg_read(10'h010, 32'h0);
      reg_write(10'h014, 32'h1);
      reg_write(10'h000, 32'h3);
      reg_write(10'h004, 32'h1);
      tick();
      check("pr_lat1_valid", 128'(match_valid), 128'h0);
      tick();
      check("pr_mask",  match_mask, 128'h1);
      check("pr_mode",  128'(match_mode),  128'h1);
      check("pr_valid", 128'(match_valid), 128'h1);

      // Statistics
      for (int i = 0; i < 5; i++) pulse(0, 0, 0, 1);
      for (int i = 0; i < 2; i++) pulse(0, 0, 1, 0);
`ifdef PSPIN_MATCH_RULE_CTRL_STATS_EN
      reg_read(10'h00C, 32'd5);
      reg_read(10'h090, 32'd2);
      reg_write(10'h00C, 32'h0);
      reg_read(10'h00C, 32'd0);
      reg_read(10'h090, 32'd0);
`else
      reg_read(10'h00C, 32'd0);
      reg_read(10'h090, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
